// File: rtl/instr_fetch_decode.sv
// Multi-cycle LEGv8 fetch/decode controller: FETCH -> DECODE -> EXEC -> WB, one instruction in flight.
// Optional feature: define FD_CBZ_EN to decode CBZ and branch on the Zero flag.
module instr_fetch_decode (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        Zero,
    output logic [5:0]  Read1,
    output logic [5:0]  Read2,
    output logic [5:0]  WriteReg,
    output logic [10:0] OpCodefield,
    output logic [8:0]  SEin,
    output logic [1:0]  ALUOp,
    output logic [1:0]  AluSrc,
    output logic        RegWrite,
    output logic        instr_done,
    output logic        illegal
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    state_t      state_q;
    logic [63:0] pc_q;
    logic [31:0] ir_q;
    logic        wr_q;
    logic        cbz_q;
    logic        taken_q;

    logic [5:0]  rn_s, rm_s, rd_s;
    logic [5:0]  read1_d, read2_d, wreg_d;
    logic [1:0]  aluop_d, alusrc_d;
    logic        wr_d, cbz_d, illegal_d;
    logic [63:0] br_off_s, pc_next_s;
    logic        unused_s;

    assign rn_s = {1'b0, ir_q[9:5]};
    assign rm_s = {1'b0, ir_q[20:16]};
    assign rd_s = {1'b0, ir_q[4:0]};

    // Control decode of the latched instruction word
    always_comb begin
        read1_d   = 6'd0;
        read2_d   = 6'd0;
        wreg_d    = 6'd0;
        aluop_d   = 2'b00;
        alusrc_d  = 2'b00;
        wr_d      = 1'b0;
        cbz_d     = 1'b0;
        illegal_d = 1'b0;
        case (ir_q[31:21])
            OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                read1_d = rn_s;
                read2_d = rm_s;
                wreg_d  = rd_s;
                aluop_d = 2'b10;
                wr_d    = 1'b1;
            end
            OP_LDUR: begin
                read1_d  = rn_s;
                wreg_d   = rd_s;
                alusrc_d = 2'b01;
                wr_d     = 1'b1;
            end
            OP_STUR: begin
                read1_d  = rn_s;
                read2_d  = rd_s;
                alusrc_d = 2'b01;
            end
            default: begin
`ifdef FD_CBZ_EN
                if (ir_q[31:24] == OP_CBZ) begin
                    read2_d = rd_s;
                    aluop_d = 2'b01;
                    cbz_d   = 1'b1;
                end else begin
                    illegal_d = 1'b1;
                end
`else
                illegal_d = 1'b1;
`endif
            end
        endcase
    end

    // Branch offset is the 19-bit word displacement in instr[23:5]; adds wrap modulo 2^64
    assign br_off_s  = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};
    assign pc_next_s = taken_q ? (pc_q + br_off_s) : (pc_q + 64'd4);
    assign unused_s  = ^{Zero, cbz_q, ir_q[11:10]};

    // Request drops in the very cycle reset is seen, so no fetch is advertised during reset
    assign imem_req  = (state_q == S_FETCH) && !reset;
    assign imem_addr = pc_q;

    // Sequencer with registered datapath/control outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= 64'd0;
            ir_q        <= 32'd0;
            wr_q        <= 1'b0;
            cbz_q       <= 1'b0;
            taken_q     <= 1'b0;
            Read1       <= 6'd0;
            Read2       <= 6'd0;
            WriteReg    <= 6'd0;
            OpCodefield <= 11'd0;
            SEin        <= 9'd0;
            ALUOp       <= 2'b00;
            AluSrc      <= 2'b00;
            RegWrite    <= 1'b0;
            instr_done  <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        state_q <= S_DECODE;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_DECODE: begin
                    Read1       <= read1_d;
                    Read2       <= read2_d;
                    WriteReg    <= wreg_d;
                    OpCodefield <= ir_q[31:21];
                    SEin        <= ir_q[20:12];
                    ALUOp       <= aluop_d;
                    AluSrc      <= alusrc_d;
                    wr_q        <= wr_d;
                    cbz_q       <= cbz_d;
                    illegal     <= illegal | illegal_d;
                    state_q     <= S_EXEC;
                end
                S_EXEC: begin
`ifdef FD_CBZ_EN
                    taken_q <= cbz_q & Zero;
`else
                    taken_q <= 1'b0;
`endif
                    RegWrite   <= wr_q;
                    instr_done <= 1'b1;
                    state_q    <= S_WB;
                end
                S_WB: begin
                    pc_q       <= pc_next_s;
                    taken_q    <= 1'b0;
                    RegWrite   <= 1'b0;
                    instr_done <= 1'b0;
                    state_q    <= S_FETCH;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Randomized self-checking bench for instr_fetch_decode against an instruction-level reference model.
module tb_instr_fetch_decode;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        Zero = 1'b0;
    logic        imem_req, RegWrite, instr_done, illegal;
    logic [63:0] imem_addr;
    logic [5:0]  Read1, Read2, WriteReg;
    logic [10:0] OpCodefield;
    logic [8:0]  SEin;
    logic [1:0]  ALUOp, AluSrc;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_done = -1;
    logic [63:0] m_pc = 64'd0;
    logic        m_ill = 1'b0;

    typedef struct packed {
        logic       legal;
        logic       cbz;
        logic       we;
        logic       c1;
        logic       c2;
        logic       cw;
        logic [5:0] r1;
        logic [5:0] r2;
        logic [5:0] wr;
        logic [1:0] aluop;
        logic [1:0] alusrc;
    } dec_t;

    instr_fetch_decode dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Zero(Zero),
        .Read1(Read1), .Read2(Read2), .WriteReg(WriteReg),
        .OpCodefield(OpCodefield), .SEin(SEin),
        .ALUOp(ALUOp), .AluSrc(AluSrc),
        .RegWrite(RegWrite), .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: no summary reached within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Instruction-level meaning of a word, straight from the ISA field layout
    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        int unsigned op, rn, rm, rt;
        d  = '0;
        op = (ins >> 21) & 32'h7FF;
        rn = (ins >> 5) & 32'h1F;
        rm = (ins >> 16) & 32'h1F;
        rt = ins & 32'h1F;
        if (op == 32'h458 || op == 32'h658 || op == 32'h450 || op == 32'h550) begin
            d.legal = 1'b1; d.we = 1'b1; d.c1 = 1'b1; d.c2 = 1'b1; d.cw = 1'b1;
            d.r1 = 6'(rn); d.r2 = 6'(rm); d.wr = 6'(rt);
            d.aluop = 2'b10; d.alusrc = 2'b00;
        end else if (op == 32'h7C2) begin
            d.legal = 1'b1; d.we = 1'b1; d.c1 = 1'b1; d.cw = 1'b1;
            d.r1 = 6'(rn); d.wr = 6'(rt);
            d.aluop = 2'b00; d.alusrc = 2'b01;
        end else if (op == 32'h7C0) begin
            d.legal = 1'b1; d.c1 = 1'b1; d.c2 = 1'b1;
            d.r1 = 6'(rn); d.r2 = 6'(rt);
            d.aluop = 2'b00; d.alusrc = 2'b01;
`ifdef FD_CBZ_EN
        end else if ((ins >> 24) == 32'hB4) begin
            d.legal = 1'b1; d.cbz = 1'b1; d.c2 = 1'b1;
            d.r2 = 6'(rt);
            d.aluop = 2'b01; d.alusrc = 2'b00;
`endif
        end else begin
            d.legal = 1'b0;
        end
        return d;
    endfunction

    function automatic logic [63:0] branch_off(input logic [31:0] ins);
        logic signed [18:0] imm;
        imm = ins[23:5];
        return 64'(longint'(imm) * 4);
    endfunction

    task automatic do_reset(input int ncyc);
        reset = 1'b1;
        imem_ack = 1'b0;
        repeat (ncyc) @(negedge clock);
        check_val("rst_req", 64'(imem_req), 64'd0);
        check_val("rst_addr", imem_addr, 64'd0);
        check_val("rst_we", 64'(RegWrite), 64'd0);
        check_val("rst_done", 64'(instr_done), 64'd0);
        check_val("rst_illegal", 64'(illegal), 64'd0);
        check_val("rst_fields", 64'({Read1, Read2, WriteReg, OpCodefield, SEin, ALUOp, AluSrc}), 64'd0);
        reset = 1'b0;
        m_pc = 64'd0;
        m_ill = 1'b0;
        last_done = -1;
    endtask

    // One full instruction: stall cycles in FETCH, then accept, then check each later phase
    task automatic run_instr(input logic [31:0] ins, input int stall, input logic z);
        dec_t d;
        int   n;
        d = ref_decode(ins);
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_val("req_fetch", 64'(imem_req), 64'd1);
        check_val("addr_fetch", imem_addr, m_pc);
        for (int i = 0; i < stall; i++) begin
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            @(negedge clock);
            check_val("req_stall", 64'(imem_req), 64'd1);
            check_val("addr_stall", imem_addr, m_pc);
        end
        imem_ack = 1'b1;
        imem_rdata = ins;
        @(negedge clock);
        imem_ack = 1'($urandom);
        imem_rdata = $urandom;
        @(negedge clock);
        check_val("req_exec", 64'(imem_req), 64'd0);
        check_val("opcodefield", 64'(OpCodefield), 64'(ins[31:21]));
        check_val("sein", 64'(SEin), 64'(ins[20:12]));
        if (d.legal) begin
            check_val("aluop", 64'(ALUOp), 64'(d.aluop));
            check_val("alusrc", 64'(AluSrc), 64'(d.alusrc));
        end
        if (d.c1) check_val("read1", 64'(Read1), 64'(d.r1));
        if (d.c2) check_val("read2", 64'(Read2), 64'(d.r2));
        if (d.cw) check_val("writereg", 64'(WriteReg), 64'(d.wr));
        check_val("we_exec", 64'(RegWrite), 64'd0);
        check_val("done_exec", 64'(instr_done), 64'd0);
        Zero = z;
        imem_ack = 1'($urandom);
        imem_rdata = $urandom;
        @(negedge clock);
        m_ill = m_ill | !d.legal;
        check_val("we_wb", 64'(RegWrite), 64'(d.we));
        check_val("done_wb", 64'(instr_done), 64'd1);
        check_val("illegal", 64'(illegal), 64'(m_ill));
        if (d.c1) check_val("read1_hold", 64'(Read1), 64'(d.r1));
        if (last_done >= 0) check_val("done_period", 64'(cyc - last_done), 64'(4 + stall));
        last_done = cyc;
        Zero = ~z;
        imem_ack = 1'($urandom);
        m_pc = (d.cbz && z) ? m_pc + branch_off(ins) : m_pc + 64'd4;
        @(negedge clock);
        imem_ack = 1'b0;
        check_val("we_after", 64'(RegWrite), 64'd0);
        check_val("done_after", 64'(instr_done), 64'd0);
        check_val("next_addr", imem_addr, m_pc);
    endtask

    task automatic reset_in_exec(input logic [31:0] ins);
        check_val("req_pre_exec_rst", 64'(imem_req), 64'd1);
        imem_ack = 1'b1;
        imem_rdata = ins;
        @(negedge clock);
        imem_ack = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_val("exec_rst_we", 64'(RegWrite), 64'd0);
        check_val("exec_rst_done", 64'(instr_done), 64'd0);
        check_val("exec_rst_req", 64'(imem_req), 64'd0);
        check_val("exec_rst_addr", imem_addr, 64'd0);
        check_val("exec_rst_read1", 64'(Read1), 64'd0);
        reset = 1'b0;
        m_pc = 64'd0;
        m_ill = 1'b0;
        last_done = -1;
    endtask

    task automatic reset_with_ack(input logic [31:0] ins);
        imem_ack = 1'b1;
        imem_rdata = ins;
        reset = 1'b1;
        @(negedge clock);
        check_val("rstack_req", 64'(imem_req), 64'd0);
        check_val("rstack_addr", imem_addr, 64'd0);
        check_val("rstack_opc", 64'(OpCodefield), 64'd0);
        reset = 1'b0;
        imem_ack = 1'b0;
        m_pc = 64'd0;
        m_ill = 1'b0;
        last_done = -1;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        do_reset(3);
        run_instr(32'h8B020023, 0, 1'b0);
        run_instr(32'hF8408085, 0, 1'b0);
        run_instr(32'hCB1F0147, 1, 1'b1);
        run_instr(32'hF80003E9, 0, 1'b1);
        run_instr(32'hB4000067, 0, 1'b1);
        run_instr(32'hB4000067, 2, 1'b0);
        run_instr(32'h8B020023, 5, 1'b0);
        reset_in_exec(32'h8B020023);
        run_instr(32'hAA0500C4, 0, 1'b0);
        reset_with_ack(32'hF8408085);
        run_instr(32'h8A1F03E0, 0, 1'b0);
        run_instr(32'h00000000, 0, 1'b0);
        run_instr(32'h8B020023, 0, 1'b0);
        do_reset(2);
        for (int k = 0; k < 60; k++) begin
            r = $urandom;
            case ($urandom_range(0, 7))
                0:       ins = {11'h458, r[20:0]};
                1:       ins = {11'h658, r[20:0]};
                2:       ins = {11'h450, r[20:0]};
                3:       ins = {11'h550, r[20:0]};
                4:       ins = {11'h7C2, r[20:0]};
                5:       ins = {11'h7C0, r[20:0]};
                6:       ins = {8'hB4, r[23:0]};
                default: ins = r;
            endcase
            run_instr(ins, int'($urandom_range(0, 3)), 1'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
